// File: rtl/free_list_pkg.sv
// free_list_pkg: shared sizes and types for the rename-stage physical register free list
`ifndef FREE_LIST_DEFS
`define FREE_LIST_DEFS
`define PRF_DEPTH 64
`define PRF_WIDTH 6
`define MACHINE_WIDTH 4
`endif
package free_list_pkg;
   localparam int PRF_DEPTH = `PRF_DEPTH;
   localparam int PRF_WIDTH = `PRF_WIDTH;
   localparam int MACHINE_WIDTH = `MACHINE_WIDTH;
   localparam int ARF_DEPTH = 32;
   localparam int FL_DEPTH = PRF_DEPTH - ARF_DEPTH;
   localparam int PTR_W = $clog2(FL_DEPTH) + 1;
   localparam int IDX_W = PTR_W - 1;
   localparam int CNT_W = $clog2(MACHINE_WIDTH + 1);
   typedef logic [PRF_WIDTH-1:0] prn_t;
   typedef logic [PTR_W-1:0] ptr_t;
endpackage

// File: rtl/fl_ret_compact.sv
// fl_ret_compact: per-lane rank (set lanes below) and popcount of a lane mask
module fl_ret_compact
   import free_list_pkg::*;
(
   input  logic [MACHINE_WIDTH-1:0]            mask,
   output logic [MACHINE_WIDTH-1:0][CNT_W-1:0] rank,
   output logic [CNT_W-1:0]                    count
);
   always_comb begin
      count = '0;
      rank = '0;
      for (int i = 0; i < MACHINE_WIDTH; i++) begin
         rank[i] = count;
         count = count + CNT_W'(mask[i]);
      end
   end
endmodule

// File: rtl/free_list.sv
// free_list: circular free PRN list with speculative head, return tail and
// retirement head so a flush restores the committed allocation point in one cycle
module free_list
   import free_list_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     pipe_flush,
   output prn_t [MACHINE_WIDTH-1:0] free_prn,
   output logic [MACHINE_WIDTH-1:0] free_prn_valid,
   input  logic [MACHINE_WIDTH-1:0] free_prn_ready,
   input  logic [MACHINE_WIDTH-1:0] commit_valid,
   input  prn_t [MACHINE_WIDTH-1:0] commit_old_prn,
   output ptr_t                     free_count
);
   prn_t fl_mem [FL_DEPTH];
   ptr_t head, tail, rhead, spec_depth;
   logic [MACHINE_WIDTH-1:0] fire;
   logic [MACHINE_WIDTH-1:0][CNT_W-1:0] alloc_rank, ret_rank;
   logic [CNT_W-1:0] n_alloc, n_ret;

   assign free_count = tail - head;
   assign spec_depth = head - rhead;
   assign fire = free_prn_valid & free_prn_ready;

   // Offers depend only on state and flush, never on ready
   always_comb begin
      for (int i = 0; i < MACHINE_WIDTH; i++) begin
         free_prn[i] = fl_mem[IDX_W'(head + ptr_t'(i))];
         free_prn_valid[i] = (free_count > ptr_t'(i)) && !pipe_flush;
      end
   end

   fl_ret_compact u_alloc_cnt (.mask(fire), .rank(alloc_rank), .count(n_alloc));
   fl_ret_compact u_ret_cnt (.mask(commit_valid), .rank(ret_rank), .count(n_ret));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         rhead <= '0;
         tail <= ptr_t'(FL_DEPTH);
         for (int k = 0; k < FL_DEPTH; k++) fl_mem[k] <= prn_t'(ARF_DEPTH + k);
      end else begin
         head <= pipe_flush ? rhead + ptr_t'(n_ret) : head + ptr_t'(n_alloc);
         tail <= tail + ptr_t'(n_ret);
         rhead <= rhead + ptr_t'(n_ret);
         for (int i = 0; i < MACHINE_WIDTH; i++)
            if (commit_valid[i]) fl_mem[IDX_W'(tail + ptr_t'(ret_rank[i]))] <= commit_old_prn[i];
      end
   end

   // Overflow is judged on the post-edge count, since allocation frees slots in the same cycle
   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < MACHINE_WIDTH; i++) begin
            assert (!fire[i] || alloc_rank[i] == CNT_W'(i))
               else $error("free_list: handshake lanes not a prefix");
            assert (!commit_valid[i] || commit_old_prn[i] != '0)
               else $error("free_list: PRN 0 returned");
         end
         assert (int'(free_count) - int'(n_alloc) + int'(n_ret) <= FL_DEPTH)
            else $error("free_list: overflow");
         assert (spec_depth <= ptr_t'(FL_DEPTH))
            else $error("free_list: rhead passed head");
      end
   end
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed checks of allocation, commit, flush, wrap and async reset
module tb_free_list;
   import free_list_pkg::*;
   logic clk = 1'b0;
   logic rst_n, pipe_flush;
   prn_t [3:0] free_prn, commit_old_prn;
   logic [3:0] free_prn_valid, free_prn_ready, commit_valid;
   ptr_t free_count;
   int passed = 0, total = 0, fails = 0;
   int q[$];

   free_list dut (
      .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
      .free_prn(free_prn), .free_prn_valid(free_prn_valid), .free_prn_ready(free_prn_ready),
      .commit_valid(commit_valid), .commit_old_prn(commit_old_prn), .free_count(free_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pv(input int a, input int b, input int c, input int d);
      return 32'({prn_t'(d), prn_t'(c), prn_t'(b), prn_t'(a)});
   endfunction

   initial begin
      rst_n = 1'b0; pipe_flush = 1'b0; free_prn_ready = '0; commit_valid = '0; commit_old_prn = '0;
      #12 rst_n = 1'b1;
      #1;
      chk("rst_count", 32'(free_count), 32);
      chk("rst_valid", 32'(free_prn_valid), 32'hf);
      chk("rst_prn", 32'(free_prn), pv(32, 33, 34, 35));
      free_prn_ready = 4'b0011;
      step;
      free_prn_ready = '0;
      chk("alloc2_prn", 32'(free_prn), pv(34, 35, 36, 37));
      chk("alloc2_count", 32'(free_count), 30);
      for (int c = 0; c < 8; c++) begin
         free_prn_ready = 4'hf;
         if (c == 7) begin
            chk("cnt2_count", 32'(free_count), 2);
            chk("cnt2_valid", 32'(free_prn_valid), 32'h3);
         end
         step;
      end
      free_prn_ready = '0;
      chk("empty_count", 32'(free_count), 0);
      chk("empty_valid", 32'(free_prn_valid), 0);
      commit_valid = 4'b0101;
      commit_old_prn[0] = 6'd5;
      commit_old_prn[2] = 6'd9;
      step;
      commit_valid = '0;
      chk("ret_count", 32'(free_count), 2);
      chk("ret_valid", 32'(free_prn_valid), 32'h3);
      chk("ret_prn0", 32'(free_prn[0]), 5);
      chk("ret_prn1", 32'(free_prn[1]), 9);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_count", 32'(free_count), 32);
      chk("arst_valid", 32'(free_prn_valid), 32'hf);
      chk("arst_prn", 32'(free_prn), pv(32, 33, 34, 35));
      #2 rst_n = 1'b1;
      step;
      free_prn_ready = 4'hf;
      repeat (3) step;
      free_prn_ready = '0;
      commit_valid = 4'hf;
      for (int i = 0; i < 4; i++) commit_old_prn[i] = prn_t'(i + 1);
      step;
      commit_valid = '0;
      free_prn_ready = 4'hf;
      step;
      chk("spec_count", 32'(free_count), 20);
      pipe_flush = 1'b1;
      #1;
      chk("flush_valid", 32'(free_prn_valid), 0);
      step;
      pipe_flush = 1'b0;
      free_prn_ready = '0;
      chk("flush_count", 32'(free_count), 32);
      chk("flush_prn", 32'(free_prn), pv(36, 37, 38, 39));
      for (int k = 36; k < 64; k++) q.push_back(k);
      for (int k = 1; k <= 4; k++) q.push_back(k);
      for (int c = 0; c < 20; c++) begin
         free_prn_ready = 4'hf;
         commit_valid = 4'hf;
         for (int i = 0; i < 4; i++) commit_old_prn[i] = prn_t'(((c * 4 + i) % 62) + 1);
         chk("wrap_count", 32'(free_count), 32);
         chk("wrap_prn", 32'(free_prn), pv(q[0], q[1], q[2], q[3]));
         step;
         for (int i = 0; i < 4; i++) begin
            void'(q.pop_front());
            q.push_back(((c * 4 + i) % 62) + 1);
         end
      end
      free_prn_ready = '0;
      commit_valid = '0;
      chk("wrap_end_count", 32'(free_count), 32);
      chk("wrap_end_prn", 32'(free_prn), pv(q[0], q[1], q[2], q[3]));
      free_prn_ready = 4'hf;
      repeat (2) step;
      free_prn_ready = '0;
      chk("spec8_count", 32'(free_count), 24);
      pipe_flush = 1'b1;
      commit_valid = 4'b0011;
      commit_old_prn[0] = 6'd7;
      commit_old_prn[1] = 6'd8;
      #1;
      chk("fc_valid", 32'(free_prn_valid), 0);
      step;
      pipe_flush = 1'b0;
      commit_valid = '0;
      void'(q.pop_front());
      void'(q.pop_front());
      q.push_back(7);
      q.push_back(8);
      chk("fc_count", 32'(free_count), 32);
      chk("fc_prn", 32'(free_prn), pv(q[0], q[1], q[2], q[3]));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
